histogram_capture_ctrl: RTL and testbench

HISTOGRAM_CAPTURE_CTRL -- requirements
Module: histogram_capture_ctrl

---
 rtl/histogram_capture_ctrl.sv | 144 ++++++++++++++
 tb/tb_histogram_capture_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_capture_ctrl.sv
// Sequences a histogram capture: bin clear sweep, wait for start of frame, accumulate N frames.
// Ends in DONE on frame count or on a vs_i inactivity timeout; abort returns to IDLE at any time.
module histogram_capture_ctrl #(
    parameter int          NUM_BINS       = 256,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] num_frames_i,
    input  logic       vs_i,
    output logic [7:0] clr_addr_o,
    output logic       clr_we_o,
    output logic       calc_flag_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       irq_o,
    output logic       timeout_o,
    output logic [7:0] frames_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_SOF,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam logic [7:0]  LAST_ADDR = 8'(NUM_BINS - 1);
    localparam logic [23:0] TMO_LAST  = TIMEOUT_CYCLES - 24'd1;

    state_t      state_q, state_d;
    logic        vs_q;
    logic [7:0]  clr_addr_q, clr_addr_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  frames_q, frames_d;
    logic        tmo_q, tmo_d;
    logic [23:0] cnt_q, cnt_d;
    logic        irq_q, irq_d;

    logic        sof;
    logic        eof;
    logic        tmo_hit;
    logic [7:0]  frames_inc;

    // vs_i high is blanking: falling edge starts a frame, rising edge ends it.
    assign sof        = vs_q & ~vs_i;
    assign eof        = ~vs_q & vs_i;
    assign tmo_hit    = (cnt_q == TMO_LAST) && !sof && !eof;
    assign frames_inc = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            vs_q       <= 1'b1;
            clr_addr_q <= '0;
            target_q   <= 8'd1;
            frames_q   <= '0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_i;
            clr_addr_q <= clr_addr_d;
            target_q   <= target_d;
            frames_q   <= frames_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        target_d   = target_q;
        frames_d   = frames_q;
        tmo_d      = tmo_q;
        cnt_d      = '0;

        if (abort_i) begin
            state_d    = S_IDLE;
            clr_addr_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        target_d   = (num_frames_i == 8'd0) ? 8'd1 : num_frames_i;
                        frames_d   = '0;
                        tmo_d      = 1'b0;
                        clr_addr_d = '0;
                        state_d    = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        clr_addr_d = '0;
                        state_d    = S_WAIT_SOF;
                    end else begin
                        clr_addr_d = clr_addr_q + 8'd1;
                    end
                end
                S_WAIT_SOF: begin
                    cnt_d = (sof || eof) ? 24'd0 : cnt_q + 24'd1;
                    if (sof) begin
                        state_d = S_ACCUM;
                    end else if (tmo_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_ACCUM: begin
                    cnt_d = (sof || eof) ? 24'd0 : cnt_q + 24'd1;
                    if (eof) begin
                        frames_d = frames_inc;
                        if (frames_inc == target_q) begin
                            state_d = S_DONE;
                        end
                    end else if (tmo_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        irq_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign clr_addr_o    = clr_addr_q;
    assign clr_we_o      = (state_q == S_CLEAR);
    assign calc_flag_o   = (state_q == S_ACCUM);
    assign busy_o        = (state_q == S_CLEAR) || (state_q == S_WAIT_SOF) || (state_q == S_ACCUM);
    assign done_o        = (state_q == S_DONE);
    assign irq_o         = irq_q;
    assign timeout_o     = tmo_q && (state_q == S_DONE);
    assign frames_done_o = frames_q;

endmodule

// File: tb/tb_histogram_capture_ctrl.sv
// Scoreboard bench: stimulus pushes expected clear addresses and capture results,
// a negedge monitor pops and compares them whenever the DUT emits clr_we_o or irq_o.
module tb_histogram_capture_ctrl;

    localparam int NBINS = 256;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] num_frames_i = 8'd0;
    logic       vs_i = 1'b1;
    logic [7:0] clr_addr_o;
    logic       clr_we_o;
    logic       calc_flag_o;
    logic       busy_o;
    logic       done_o;
    logic       irq_o;
    logic       timeout_o;
    logic [7:0] frames_done_o;

    histogram_capture_ctrl #(
        .NUM_BINS       (NBINS),
        .TIMEOUT_CYCLES (24'(TMO))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .num_frames_i  (num_frames_i),
        .vs_i          (vs_i),
        .clr_addr_o    (clr_addr_o),
        .clr_we_o      (clr_we_o),
        .calc_flag_o   (calc_flag_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .irq_o         (irq_o),
        .timeout_o     (timeout_o),
        .frames_done_o (frames_done_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] clr_q[$];
    logic [8:0] done_q[$];   // {timeout, frames_done}
    logic       prev_irq = 1'b0;
    logic [8:0] exp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clr_we_o === 1'b1) begin
            check("clr_pending", 32'(clr_q.size() != 0), 1);
            if (clr_q.size() != 0) check("clr_addr", clr_addr_o, clr_q.pop_front());
        end else if (rst === 1'b1) begin
            check("clr_addr_idle", clr_addr_o, 0);
        end
        if (irq_o === 1'b1) begin
            check("irq_width", prev_irq, 0);
            check("irq_pending", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                exp_done = done_q.pop_front();
                check("done_frames", frames_done_o, exp_done[7:0]);
                check("done_timeout", timeout_o, exp_done[8]);
                check("done_level", done_o, 1);
            end
        end
        prev_irq = irq_o;
    end

    task automatic do_start(input logic [7:0] n);
        for (int a = 0; a < NBINS; a++) clr_q.push_back(8'(a));
        start_i      = 1'b1;
        num_frames_i = n;
        @(negedge clk);
        start_i      = 1'b0;
        num_frames_i = $urandom_range(0, 255);
    endtask

    task automatic wait_clear_end();
        int len;
        len = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (clr_we_o !== 1'b1) break;
            len++;
        end
        check("clear_end", clr_we_o, 0);
        check("clear_len", len, NBINS);
    endtask

    task automatic frame(input bit first, input bit last);
        repeat ($urandom_range(2, 20)) @(negedge clk);
        if (first) check("calc_before_sof", calc_flag_o, 0);
        vs_i = 1'b0;
        @(negedge clk);
        check("calc_after_sof", calc_flag_o, 1);
        repeat ($urandom_range(3, 40)) @(negedge clk);
        vs_i = 1'b1;
        @(negedge clk);
        check("calc_after_eof", calc_flag_o, 32'(!last));
        check("done_after_eof", done_o, 32'(last));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 250 && done_o !== 1'b1; i++) @(negedge clk);
        check("done_reached", done_o, 1);
    endtask

    // Reference: a capture ends with eff frames unless vs_i stalls first, then it ends with
    // the frames seen so far and the timeout flag set.
    task automatic capture(input logic [7:0] n, input int tmo_after);
        int eff;
        eff = (n == 8'd0) ? 1 : int'(n);
        if (tmo_after < 0) done_q.push_back({1'b0, 8'(eff)});
        else               done_q.push_back({1'b1, 8'(tmo_after)});
        do_start(n);
        wait_clear_end();
        if (tmo_after < 0) begin
            for (int i = 0; i < eff; i++) frame(i == 0, i == eff - 1);
        end else begin
            for (int i = 0; i < tmo_after; i++) frame(i == 0, 1'b0);
            wait_done();
            check("tmo_flag", timeout_o, 1);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int wcnt;
        bit calc_seen;
        logic [7:0] n;
        int k;

        #12;
        check("reset_outputs", {clr_addr_o, clr_we_o, calc_flag_o, busy_o, done_o, irq_o,
                                timeout_o, frames_done_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // start and abort together in IDLE: abort wins
        start_i = 1'b1; abort_i = 1'b1; num_frames_i = 8'd3;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        check("start_abort_busy", busy_o, 0);
        check("start_abort_clr", clr_we_o, 0);
        repeat (2) @(negedge clk);

        // two-frame capture, third pulse must not count
        capture(8'd2, -1);
        check("two_frames_done", frames_done_o, 2);
        vs_i = 1'b0; repeat (5) @(negedge clk);
        vs_i = 1'b1; repeat (3) @(negedge clk);
        check("extra_pulse_frames", frames_done_o, 2);
        check("extra_pulse_done", done_o, 1);
        check("extra_pulse_calc", calc_flag_o, 0);
        check("extra_pulse_tmo", timeout_o, 0);

        // zero frames requested behaves as one
        capture(8'd0, -1);
        check("zero_frames_done", frames_done_o, 1);
        check("zero_frames_level", done_o, 1);

        // vs_i stuck low: timeout exactly TMO cycles after the clear sweep
        vs_i = 1'b0;
        repeat (3) @(negedge clk);
        done_q.push_back({1'b1, 8'd0});
        do_start(8'd1);
        wait_clear_end();
        wcnt = 0; calc_seen = 0;
        for (int i = 0; i < 300 && done_o !== 1'b1; i++) begin
            if (busy_o) wcnt++;
            if (calc_flag_o) calc_seen = 1'b1;
            @(negedge clk);
        end
        check("tmo_wait_cycles", wcnt, TMO);
        check("tmo_calc_never", calc_seen, 0);
        check("tmo_done", done_o, 1);
        check("tmo_flag_set", timeout_o, 1);
        vs_i = 1'b1;
        repeat (3) @(negedge clk);

        // abort after one of three frames; a second start in ACCUM is ignored
        do_start(8'd3);
        wait_clear_end();
        frame(1'b1, 1'b0);
        start_i = 1'b1; num_frames_i = 8'd1;
        @(negedge clk);
        start_i = 1'b0;
        check("restart_ignored_busy", busy_o, 1);
        check("restart_ignored_calc", calc_flag_o, 1);
        check("restart_ignored_frames", frames_done_o, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_calc", calc_flag_o, 0);
        check("abort_done", done_o, 0);
        check("abort_frames", frames_done_o, 1);
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of the clear sweep
        do_start(8'd4);
        for (int i = 0; i < 100 && clr_addr_o !== 8'd17; i++) @(negedge clk);
        check("clr_reached_17", clr_addr_o, 17);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {clr_addr_o, clr_we_o, calc_flag_o, busy_o, done_o, irq_o,
                                      timeout_o, frames_done_o}, 0);
        clr_q.delete();
        @(negedge clk);
        rst = 1'b1;
        capture(8'd1, -1);

        // randomized captures, some ending in timeout
        for (int t = 0; t < 8; t++) begin
            n = 8'($urandom_range(0, 5));
            k = -1;
            if ($urandom_range(0, 3) == 0) k = $urandom_range(0, (n == 8'd0) ? 0 : int'(n) - 1);
            capture(n, k);
        end

        repeat (20) @(negedge clk);
        check("clr_queue_drained", clr_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
